// File: rtl/multiply_pipe_if.sv
// Handshake bundle for multiply_pipe: operand stream in, result stream out.
// W is the operand/result width; arg_dat packs {b, a}.
interface multiply_pipe_if #(
   parameter int W = 16
);
   logic           arg_stb;
   logic [2*W-1:0] arg_dat;
   logic           arg_rdy;
   logic           res_stb;
   logic [W-1:0]   res_dat;
   logic           res_ovf;
   logic           res_rdy;

   // Producer/consumer side driving operands and accepting results.
   modport master (
      output arg_stb, arg_dat, res_rdy,
      input  arg_rdy, res_stb, res_dat, res_ovf
   );

   // Multiplier side.
   modport slave (
      input  arg_stb, arg_dat, res_rdy,
      output arg_rdy, res_stb, res_dat, res_ovf
   );
endinterface

// File: rtl/multiply_pipe.sv
// Signed Q-format multiplier with a D-stage elastic pipeline, optional
// round-half-up and saturation back to W bits.
module multiply_pipe #(
   parameter int W   = 16,
   parameter int Q   = 8,
   parameter int D   = 3,
   parameter int RND = 1,
   parameter int SAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   multiply_pipe_if.slave bus
);

   if (W < 2 || Q < 1 || Q > W || D < 1) begin : g_bad_param
      $fatal(1, "multiply_pipe: illegal parameters W=%0d Q=%0d D=%0d", W, Q, D);
   end

   localparam logic [2*W:0] RndC = (RND != 0) ? ((2*W+1)'(1) << (Q - 1)) : '0;

   // Round, shift and fit a full-width product; returns {ovf, dat}.
   function automatic logic [W:0] f_finish(input logic [2*W-1:0] i_p);
      logic signed [2*W:0] l_s;
      logic signed [2*W:0] l_t;
      logic                l_ovf;
      logic [W-1:0]        l_dat;
      l_s   = $signed({i_p[2*W-1], i_p}) + $signed(RndC);
      l_t   = l_s >>> Q;
      // In range iff every bit from the result sign upward agrees.
      l_ovf = ~((&l_t[2*W:W-1]) | ~(|l_t[2*W:W-1]));
      if (l_ovf && (SAT != 0)) begin
         l_dat = l_t[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         l_dat = l_t[W-1:0];
      end
      return {l_ovf, l_dat};
   endfunction

   logic [D-1:0]   r_v;
   logic [D-1:0]   w_adv;
   logic [D-1:0]   w_in;
   logic           w_arg_rdy;
   logic           w_accept;
   logic [2*W-1:0] w_a;
   logic [2*W-1:0] w_b;
   logic [2*W-1:0] w_prod;
   logic [W-1:0]   r_dat;
   logic           r_ovf;

   assign w_a    = {{W{bus.arg_dat[W-1]}}, bus.arg_dat[W-1:0]};
   assign w_b    = {{W{bus.arg_dat[2*W-1]}}, bus.arg_dat[2*W-1:W]};
   assign w_prod = w_a * w_b;

   // A stage moves on if the consumer takes the tail or any later stage is empty.
   always_comb begin : p_adv
      logic l_full;
      l_full = 1'b1;
      w_adv  = '0;
      for (int k = D - 1; k >= 0; k--) begin
         w_adv[k] = r_v[k] & (bus.res_rdy | ~l_full);
         l_full   = l_full & r_v[k];
      end
   end

   assign w_arg_rdy = ~r_v[0] | w_adv[0];
   assign w_accept  = bus.arg_stb & w_arg_rdy;

   always_comb begin
      w_in    = '0;
      w_in[0] = w_accept;
      for (int k = 1; k < D; k++) begin
         w_in[k] = w_adv[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v <= '0;
      end else begin
         r_v <= w_in | (r_v & ~w_adv);
      end
   end

   if (D == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_dat <= '0;
            r_ovf <= 1'b0;
         end else if (w_in[0]) begin
            {r_ovf, r_dat} <= f_finish(w_prod);
         end
      end
   end else begin : g_multi
      // Product is registered at entry; rounding and fitting happen on the last hop.
      logic [2*W-1:0] r_prod [D-1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k < D - 1; k++) begin
               r_prod[k] <= '0;
            end
            r_dat <= '0;
            r_ovf <= 1'b0;
         end else begin
            if (w_in[0]) begin
               r_prod[0] <= w_prod;
            end
            for (int k = 1; k < D - 1; k++) begin
               if (w_in[k]) begin
                  r_prod[k] <= r_prod[k-1];
               end
            end
            if (w_in[D-1]) begin
               {r_ovf, r_dat} <= f_finish(r_prod[D-2]);
            end
         end
      end
   end

   assign bus.arg_rdy = w_arg_rdy;
   assign bus.res_stb = r_v[D-1];
   assign bus.res_dat = r_dat;
   assign bus.res_ovf = r_ovf;

endmodule

// File: tb/tb_multiply_pipe.sv
// Self-checking bench for multiply_pipe: five configurations, a scoreboard
// fed by an arithmetic model, plus directed literal cases.
module tb_multiply_pipe;

   localparam int N = 5;
   localparam int W = 16;

   function automatic int cfg_d(input int i);
      case (i)
         0: return 3;
         1: return 3;
         2: return 1;
         3: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int cfg_rnd(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   function automatic int cfg_sat(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   logic           clk = 1'b0;
   logic           rst;
   logic           stb  [N];
   logic [2*W-1:0] dat  [N];
   logic           rrdy [N];
   logic           ardy [N];
   logic           rstb [N];
   logic [W-1:0]   rdat [N];
   logic           rovf [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      multiply_pipe_if #(.W(W)) u_if ();
      assign u_if.arg_stb = stb[g];
      assign u_if.arg_dat = dat[g];
      assign u_if.res_rdy = rrdy[g];
      assign ardy[g]      = u_if.arg_rdy;
      assign rstb[g]      = u_if.res_stb;
      assign rdat[g]      = u_if.res_dat;
      assign rovf[g]      = u_if.res_ovf;

      multiply_pipe #(
         .W  (W),
         .Q  (8),
         .D  (cfg_d(g)),
         .RND(cfg_rnd(g)),
         .SAT(cfg_sat(g))
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(u_if.slave)
      );
   end

   int          checks = 0;
   int          errors = 0;
   logic [16:0] exp_mem [N][256];
   int          head [N];
   int          tail [N];
   int          acc  [N];
   bit          held [N];
   logic [16:0] held_v [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer product, optional +half LSB, floor-divide by 2^8, then fit.
   function automatic logic [16:0] model(input int i, input logic [31:0] d);
      longint      a, b, t;
      logic        ovf;
      logic [15:0] res;
      a   = longint'($signed(d[15:0]));
      b   = longint'($signed(d[31:16]));
      t   = (a * b + ((cfg_rnd(i) != 0) ? 128 : 0)) >>> 8;
      ovf = (t > 32767) || (t < -32768);
      if (ovf && cfg_sat(i) != 0) res = (t > 0) ? 16'h7FFF : 16'h8000;
      else                        res = t[15:0];
      return {ovf, res};
   endfunction

   function automatic logic [31:0] rand_pair();
      logic [15:0] a, b;
      logic [15:0] ext [4];
      ext = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
      case ($urandom_range(0, 3))
         0: begin
            a = 16'($urandom_range(0, 2047) - 1024);
            b = 16'($urandom_range(0, 2047) - 1024);
         end
         1: begin
            a = ext[$urandom_range(0, 3)];
            b = ext[$urandom_range(0, 3)];
         end
         default: begin
            a = 16'($urandom);
            b = 16'($urandom);
         end
      endcase
      return {b, a};
   endfunction

   task automatic scoreboard();
      for (int i = 0; i < N; i++) begin
         if (held[i]) begin
            chk($sformatf("stall_hold[%0d]", i), {14'd0, rstb[i], rovf[i], rdat[i]},
                {14'd0, 1'b1, held_v[i]});
         end
         held[i]   = rstb[i] && !rrdy[i];
         held_v[i] = {rovf[i], rdat[i]};
         if (head[i] == tail[i]) begin
            chk($sformatf("empty_stb[%0d]", i), {31'd0, rstb[i]}, 32'd0);
         end else if (rstb[i] && rrdy[i]) begin
            chk($sformatf("result[%0d]#%0d", i, head[i]), {15'd0, rovf[i], rdat[i]},
                {15'd0, exp_mem[i][head[i] % 256]});
            head[i]++;
         end
         if (stb[i] && ardy[i]) begin
            exp_mem[i][tail[i] % 256] = model(i, dat[i]);
            tail[i]++;
            acc[i]++;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!rst) scoreboard();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_model();
      for (int i = 0; i < N; i++) begin
         head[i] = tail[i];
         held[i] = 1'b0;
      end
   endtask

   task automatic directed(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] edat, input logic eovf);
      int n;
      chk($sformatf("model[%0d] %h*%h", i, a, b), {15'd0, model(i, {b, a})},
          {15'd0, eovf, edat});
      rrdy[i] = 1'b1;
      stb[i]  = 1'b1;
      dat[i]  = {b, a};
      #1;
      chk($sformatf("dir_rdy[%0d]", i), {31'd0, ardy[i]}, 32'd1);
      tick();
      stb[i] = 1'b0;
      n = 0;
      while (!rstb[i] && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("latency[%0d] %h*%h", i, a, b), 32'(n), 32'(cfg_d(i) - 1));
      chk($sformatf("direct[%0d] %h*%h", i, a, b), {15'd0, rovf[i], rdat[i]},
          {15'd0, eovf, edat});
      tick();
   endtask

   initial begin
      int cyc;
      int stale;
      int base;
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         stb[i]  = 1'b0;
         dat[i]  = '0;
         rrdy[i] = 1'b1;
         head[i] = 0;
         tail[i] = 0;
         acc[i]  = 0;
         held[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst_out[%0d]", i), {14'd0, rstb[i], rovf[i], rdat[i]}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst_rdy[%0d]", i), {31'd0, ardy[i]}, 32'd1);
         chk($sformatf("post_rst_out[%0d]", i), {14'd0, rstb[i], rovf[i], rdat[i]}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Directed literal cases.
      directed(0, 16'h0180, 16'h0200, 16'h0300, 1'b0);
      directed(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
      directed(0, 16'h8000, 16'h7FFF, 16'h8000, 1'b1);
      directed(0, 16'h0001, 16'h0080, 16'h0001, 1'b0);
      directed(0, 16'hFFFF, 16'h0080, 16'h0000, 1'b0);
      directed(1, 16'h7FFF, 16'h7FFF, 16'hFF00, 1'b1);
      directed(1, 16'h0001, 16'h0080, 16'h0000, 1'b0);
      directed(1, 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0);
      directed(2, 16'h0180, 16'h0200, 16'h0300, 1'b0);
      directed(3, 16'h0180, 16'h0200, 16'h0300, 1'b0);
      directed(4, 16'h0180, 16'h0200, 16'h0300, 1'b0);

      // Back-pressure on the two D=3 instances: five offers, three accepted.
      for (int i = 0; i < 2; i++) begin
         acc[i]  = 0;
         rrdy[i] = 1'b0;
         stb[i]  = 1'b1;
      end
      repeat (5) begin
         for (int i = 0; i < 2; i++) dat[i] = rand_pair();
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("full_acc[%0d]", i), 32'(acc[i]), 32'd3);
         chk($sformatf("full_rdy[%0d]", i), {31'd0, ardy[i]}, 32'd0);
      end
      cyc = 0;
      while ((acc[0] < 67 || acc[1] < 67) && cyc < 3000) begin
         for (int i = 0; i < 2; i++) begin
            stb[i]  = (acc[i] < 67) && ($urandom_range(0, 3) != 0);
            dat[i]  = rand_pair();
            rrdy[i] = 1'($urandom_range(0, 1));
         end
         tick();
         cyc++;
      end
      for (int i = 0; i < 2; i++) begin
         stb[i]  = 1'b0;
         rrdy[i] = 1'b1;
         chk($sformatf("bp_accepted[%0d]", i), 32'(acc[i]), 32'd67);
      end
      cyc = 0;
      while ((head[0] != tail[0] || head[1] != tail[1]) && cyc < 50) begin
         tick();
         cyc++;
      end
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("bp_drained[%0d]", i), 32'(tail[i] - head[i]), 32'd0);
      end

      // Streaming on D=1,2,4.
      for (int i = 2; i < N; i++) begin
         stb[i]  = 1'b1;
         rrdy[i] = 1'b1;
      end
      for (int c = 0; c < 100; c++) begin
         for (int i = 2; i < N; i++) dat[i] = rand_pair();
         tick();
         for (int i = 2; i < N; i++) begin
            chk($sformatf("stream_rdy[%0d]@%0d", i, c), {31'd0, ardy[i]}, 32'd1);
            if (c >= cfg_d(i) - 1) begin
               chk($sformatf("stream_stb[%0d]@%0d", i, c), {31'd0, rstb[i]}, 32'd1);
            end
         end
      end
      for (int i = 2; i < N; i++) stb[i] = 1'b0;
      repeat (8) tick();
      for (int i = 2; i < N; i++) begin
         chk($sformatf("stream_drained[%0d]", i), 32'(tail[i] - head[i]), 32'd0);
      end

      // Mid-stream reset with the D=4 pipeline full.
      base    = acc[4];
      rrdy[4] = 1'b0;
      stb[4]  = 1'b1;
      repeat (6) begin
         dat[4] = rand_pair();
         tick();
      end
      chk("rst_fill_acc", 32'(acc[4] - base), 32'd4);
      chk("rst_fill_rdy", {31'd0, ardy[4]}, 32'd0);
      chk("rst_fill_stb", {31'd0, rstb[4]}, 32'd1);
      stb[4] = 1'b0;
      #2;
      rst = 1'b1;
      flush_model();
      #1;
      chk("midrst_out", {14'd0, rstb[4], rovf[4], rdat[4]}, 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_rdy", {31'd0, ardy[4]}, 32'd1);
      @(posedge clk);
      #1;
      rrdy[4] = 1'b1;
      stale = 0;
      repeat (10) begin
         tick();
         if (rstb[4]) stale++;
      end
      chk("midrst_stale", 32'(stale), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
